// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decodes IF/ID, carries control through ID/EX, EX/MEM, MEM/WB.
// Define HAZARD_DETECT_EN to enable load-use stall detection and the saturating stall counter.
module pipe_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = 31
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instr,
  input  logic               InstrValid,
  input  logic               BranchTaken,
  output logic               PCWrite,
  output logic               IfIdWrite,
  output logic               IfIdFlush,
  output logic [1:0]         IdEx_RegWrite,
  output logic [1:0]         IdEx_MemWrite,
  output logic [1:0]         IdEx_MemRead,
  output logic [ALUOP_W-1:0] IdEx_ALUOp,
  output logic               IdEx_ALUSrc,
  output logic               IdEx_Shift,
  output logic               IdEx_MemtoReg,
  output logic               IdEx_Branch,
  output logic               IdEx_Jal,
  output logic [1:0]         IdEx_PCSrc,
  output logic [REG_AW-1:0]  IdEx_WriteReg,
  output logic [1:0]         ExMem_RegWrite,
  output logic [1:0]         ExMem_MemWrite,
  output logic [1:0]         ExMem_MemRead,
  output logic               ExMem_MemtoReg,
  output logic [REG_AW-1:0]  ExMem_WriteReg,
  output logic [1:0]         MemWb_RegWrite,
  output logic               MemWb_MemtoReg,
  output logic               MemWb_Jal,
  output logic [REG_AW-1:0]  MemWb_WriteReg,
  output logic [CNT_W-1:0]   StallCount,
  output logic               IllegalOp
);

  typedef struct packed {
    logic [1:0]         reg_write;
    logic [1:0]         mem_write;
    logic [1:0]         mem_read;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               shift;
    logic               mem_to_reg;
    logic               branch;
    logic               jal;
    logic [1:0]         pc_src;
    logic [REG_AW-1:0]  write_reg;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]        reg_write;
    logic [1:0]        mem_write;
    logic [1:0]        mem_read;
    logic              mem_to_reg;
    logic              jal;
    logic [REG_AW-1:0] write_reg;
  } ex_mem_t;

  typedef struct packed {
    logic [1:0]        reg_write;
    logic              mem_to_reg;
    logic              jal;
    logic [REG_AW-1:0] write_reg;
  } mem_wb_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_BZ   = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_BLEZ = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_BGTZ = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_BEQ  = ALUOP_W'(12);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  ctrl_t             dec;
  logic              illegal;
  logic              stall;
  ctrl_t             id_ex_reg;
  ctrl_t             id_ex_next;
  ex_mem_t           ex_mem_reg;
  mem_wb_t           mem_wb_reg;
  logic              illegal_reg;
  logic              unused_shamt;

  assign opcode       = Instr[31:26];
  assign funct        = Instr[5:0];
  assign rs           = REG_AW'(Instr[25:21]);
  assign rt           = REG_AW'(Instr[20:16]);
  assign rd           = REG_AW'(Instr[15:11]);
  assign unused_shamt = ^Instr[10:6];

  always_comb begin
    dec            = '0;
    illegal        = 1'b0;
    dec.mem_to_reg = 1'b1;
    case (opcode)
      6'h00: begin
        dec.reg_write = 2'd1;
        dec.write_reg = rd;
        if (funct == 6'h00 || funct == 6'h02) begin
          dec.alu_src = 1'b1;
          dec.shift   = 1'b1;
        end
        if (funct == 6'h08) begin
          dec.reg_write = 2'd0;
          dec.pc_src    = 2'd3;
        end
      end
      6'h23, 6'h20, 6'h21: begin
        dec.reg_write  = (opcode == 6'h23) ? 2'd1 : (opcode == 6'h20) ? 2'd2 : 2'd3;
        dec.mem_read   = dec.reg_write;
        dec.alu_op     = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b0;
        dec.write_reg  = rt;
      end
      6'h2B, 6'h28, 6'h29: begin
        dec.mem_write = (opcode == 6'h2B) ? 2'd1 : (opcode == 6'h28) ? 2'd2 : 2'd3;
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.write_reg = rt;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: begin
        dec.reg_write = 2'd1;
        dec.alu_src   = 1'b1;
        dec.write_reg = rt;
        case (opcode)
          6'h08:   dec.alu_op = ALU_ADD;
          6'h0C:   dec.alu_op = ALU_AND;
          6'h0D:   dec.alu_op = ALU_OR;
          6'h0E:   dec.alu_op = ALU_XOR;
          default: dec.alu_op = ALU_SLT;
        endcase
      end
      6'h1C: begin
        dec.reg_write = 2'd1;
        dec.alu_op    = ALU_MUL;
        dec.write_reg = rd;
      end
      6'h05, 6'h01, 6'h06, 6'h07, 6'h04: begin
        dec.branch = 1'b1;
        case (opcode)
          6'h05:   dec.alu_op = ALU_BNE;
          6'h01:   dec.alu_op = ALU_BZ;
          6'h06:   dec.alu_op = ALU_BLEZ;
          6'h07:   dec.alu_op = ALU_BGTZ;
          default: dec.alu_op = ALU_BEQ;
        endcase
      end
      6'h02: dec.pc_src = 2'd2;
      6'h03: begin
        dec.pc_src    = 2'd2;
        dec.jal       = 1'b1;
        dec.reg_write = 2'd1;
        dec.write_reg = REG_AW'(LINK_REG);
      end
      default: begin
        dec     = '0;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef HAZARD_DETECT_EN
  logic             rt_source;
  logic [CNT_W-1:0] stall_count_reg;

  // rt is only a read operand for R-type, branches and stores.
  assign rt_source = (opcode == 6'h00) || dec.branch || (dec.mem_write != 2'd0);
  assign stall = (id_ex_reg.mem_read != 2'd0) && (id_ex_reg.write_reg != '0) && InstrValid &&
                 ((id_ex_reg.write_reg == rs) || (rt_source && (id_ex_reg.write_reg == rt)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_count_reg <= '0;
    end else if (stall && !BranchTaken && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end
  assign StallCount = stall_count_reg;
`else
  logic unused_rs;
  assign unused_rs  = ^rs;
  assign stall      = 1'b0;
  assign StallCount = '0;
`endif

  assign PCWrite   = ~stall | BranchTaken;
  assign IfIdWrite = ~stall | BranchTaken;
  assign IfIdFlush = BranchTaken | (InstrValid & dec.pc_src[1]);

  // A taken branch squashes ID even when a stall is also pending.
  assign id_ex_next = (BranchTaken || stall || !InstrValid) ? '0 : dec;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      id_ex_reg   <= '0;
      ex_mem_reg  <= '0;
      mem_wb_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      id_ex_reg             <= id_ex_next;
      ex_mem_reg.reg_write  <= id_ex_reg.reg_write;
      ex_mem_reg.mem_write  <= id_ex_reg.mem_write;
      ex_mem_reg.mem_read   <= id_ex_reg.mem_read;
      ex_mem_reg.mem_to_reg <= id_ex_reg.mem_to_reg;
      ex_mem_reg.jal        <= id_ex_reg.jal;
      ex_mem_reg.write_reg  <= id_ex_reg.write_reg;
      mem_wb_reg.reg_write  <= ex_mem_reg.reg_write;
      mem_wb_reg.mem_to_reg <= ex_mem_reg.mem_to_reg;
      mem_wb_reg.jal        <= ex_mem_reg.jal;
      mem_wb_reg.write_reg  <= ex_mem_reg.write_reg;
      illegal_reg           <= illegal_reg | (InstrValid & illegal & ~BranchTaken);
    end
  end

  assign IdEx_RegWrite  = id_ex_reg.reg_write;
  assign IdEx_MemWrite  = id_ex_reg.mem_write;
  assign IdEx_MemRead   = id_ex_reg.mem_read;
  assign IdEx_ALUOp     = id_ex_reg.alu_op;
  assign IdEx_ALUSrc    = id_ex_reg.alu_src;
  assign IdEx_Shift     = id_ex_reg.shift;
  assign IdEx_MemtoReg  = id_ex_reg.mem_to_reg;
  assign IdEx_Branch    = id_ex_reg.branch;
  assign IdEx_Jal       = id_ex_reg.jal;
  assign IdEx_PCSrc     = id_ex_reg.pc_src;
  assign IdEx_WriteReg  = id_ex_reg.write_reg;
  assign ExMem_RegWrite = ex_mem_reg.reg_write;
  assign ExMem_MemWrite = ex_mem_reg.mem_write;
  assign ExMem_MemRead  = ex_mem_reg.mem_read;
  assign ExMem_MemtoReg = ex_mem_reg.mem_to_reg;
  assign ExMem_WriteReg = ex_mem_reg.write_reg;
  assign MemWb_RegWrite = mem_wb_reg.reg_write;
  assign MemWb_MemtoReg = mem_wb_reg.mem_to_reg;
  assign MemWb_Jal      = mem_wb_reg.jal;
  assign MemWb_WriteReg = mem_wb_reg.write_reg;
  assign IllegalOp      = illegal_reg;

endmodule
